// File: rtl/alu_acc_display.sv
// Saturating signed accumulator behind the lab ALU, driving a registered 7-segment code.
// Latency: result accepted on edge N, acc/SEG valid after edge N+1, res_ready back after edge N+1+HOLD_CYCLES.
// Backpressure: res_ready is high only in IDLE, so at most one result per HOLD_CYCLES+2 cycles.
// Build option: define ALU_ACC_WRAP_EN to wrap the accumulator instead of saturating (flags still set).
module alu_acc_display #(
    parameter int NBITS_IN    = 3,
    parameter int NBITS_ACC   = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                        clk_2,
    input  logic                        reset,
    input  logic signed [NBITS_IN-1:0]  res_in,
    input  logic                        res_valid,
    output logic                        res_ready,
    input  logic                        clr,
    output logic signed [NBITS_ACC-1:0] acc,
    output logic                        ovf,
    output logic                        unf,
    output logic                        busy,
    output logic [7:0]                  SEG
);

    // Counter only ever holds HOLD_CYCLES-1 down to 0.
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [7:0] SEG_ZERO = 8'b00111111;
    localparam logic [7:0] SEG_OVF  = 8'b10111111;
    localparam logic [7:0] SEG_UNF  = 8'b10111110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_SHOW
    } state_t;

    state_t                     r_state;
    logic [NBITS_IN-1:0]        r_op;
    logic [NBITS_ACC-1:0]       r_acc;
    logic                       r_ovf;
    logic                       r_unf;
    logic [7:0]                 r_seg;
    logic [CW-1:0]              r_cnt;

    logic [NBITS_ACC:0]         w_sum;
    logic                       w_pos_ovf;
    logic                       w_neg_ovf;
    logic [NBITS_ACC-1:0]       w_acc_nxt;
    logic                       w_ovf_nxt;
    logic                       w_unf_nxt;

    // Display code for a value/flag combination; flags override the digit, dp marks negatives.
    function automatic logic [7:0] seg_code(input logic [NBITS_ACC-1:0] a,
                                            input logic o, input logic u);
        logic [NBITS_ACC:0] mag;
        logic [6:0]         digit;
        logic [7:0]         code;
        mag = a[NBITS_ACC-1] ? ((NBITS_ACC+1)'(0) - {a[NBITS_ACC-1], a}) : {1'b0, a};
        case (int'(mag))
            0:       digit = 7'b0111111;
            1:       digit = 7'b0000110;
            2:       digit = 7'b1011011;
            3:       digit = 7'b1001111;
            4:       digit = 7'b1100110;
            5:       digit = 7'b1101101;
            6:       digit = 7'b1111101;
            7:       digit = 7'b0000111;
            8:       digit = 7'b1111111;
            9:       digit = 7'b1101111;
            default: digit = 7'b1111001;
        endcase
        if (o)
            code = SEG_OVF;
        else if (u)
            code = SEG_UNF;
        else
            code = {a[NBITS_ACC-1], digit};
        return code;
    endfunction

    // Next accumulator value: one guard bit catches overflow as a mismatch of the top two sum bits.
    always_comb begin
        w_sum     = {{(NBITS_ACC+1-NBITS_IN){r_op[NBITS_IN-1]}}, r_op}
                  + {r_acc[NBITS_ACC-1], r_acc};
        w_pos_ovf = ~w_sum[NBITS_ACC] &  w_sum[NBITS_ACC-1];
        w_neg_ovf =  w_sum[NBITS_ACC] & ~w_sum[NBITS_ACC-1];
        w_ovf_nxt = r_ovf | w_pos_ovf;
        w_unf_nxt = r_unf | w_neg_ovf;
`ifdef ALU_ACC_WRAP_EN
        w_acc_nxt = w_sum[NBITS_ACC-1:0];
`else
        if (w_pos_ovf)
            w_acc_nxt = {1'b0, {(NBITS_ACC-1){1'b1}}};
        else if (w_neg_ovf)
            w_acc_nxt = {1'b1, {(NBITS_ACC-1){1'b0}}};
        else
            w_acc_nxt = w_sum[NBITS_ACC-1:0];
`endif
    end

    // Control FSM plus all architectural state; reset and clr both return to the cleared image.
    always_ff @(posedge clk_2) begin
        if (!reset || clr) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_seg   <= SEG_ZERO;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (res_valid) begin
                        r_op    <= res_in;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_acc   <= w_acc_nxt;
                    r_ovf   <= w_ovf_nxt;
                    r_unf   <= w_unf_nxt;
                    r_seg   <= seg_code(w_acc_nxt, w_ovf_nxt, w_unf_nxt);
                    r_cnt   <= CW'(HOLD_CYCLES - 1);
                    r_state <= S_SHOW;
                end
                S_SHOW: begin
                    if (r_cnt == '0)
                        r_state <= S_IDLE;
                    else
                        r_cnt <= r_cnt - 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign res_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign acc       = r_acc;
    assign ovf       = r_ovf;
    assign unf       = r_unf;
    assign SEG       = r_seg;

endmodule

// File: tb/tb_alu_acc_display.sv
// Directed bench for alu_acc_display: each scenario task drives vectors and checks hand-computed results.
// Inputs change and outputs are sampled on the falling clock edge.
// Prints one summary line with check and error counts.
module tb_alu_acc_display;

    logic              clk_2;
    logic              reset;
    logic signed [2:0] res_in;
    logic              res_valid;
    logic              res_ready;
    logic              clr;
    logic signed [3:0] acc;
    logic              ovf;
    logic              unf;
    logic              busy;
    logic [7:0]        SEG;

    int checks = 0;
    int errors = 0;

    alu_acc_display #(.NBITS_IN(3), .NBITS_ACC(4), .HOLD_CYCLES(2)) dut (
        .clk_2     (clk_2),
        .reset     (reset),
        .res_in    (res_in),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .clr       (clr),
        .acc       (acc),
        .ovf       (ovf),
        .unf       (unf),
        .busy      (busy),
        .SEG       (SEG)
    );

    initial begin
        clk_2 = 1'b0;
        forever #5 clk_2 = ~clk_2;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic apply_reset();
        reset = 1'b0; clr = 1'b0; res_valid = 1'b0; res_in = '0;
        repeat (2) @(negedge clk_2);
        reset = 1'b1;
        @(negedge clk_2);
    endtask

    // Waits (bounded) for res_ready, transfers one value, then counts cycles until res_ready returns.
    task automatic push(input logic signed [2:0] v, output int lowcnt);
        int w;
        w = 0;
        while (res_ready !== 1'b1 && w < 20) begin
            @(negedge clk_2);
            w++;
        end
        checks++;
        if (res_ready !== 1'b1) begin
            errors++;
            $display("FAIL push_wait_ready: res_ready=%b required 1", res_ready);
        end
        res_in = v; res_valid = 1'b1;
        @(negedge clk_2);
        res_valid = 1'b0;
        lowcnt = 0;
        while (res_ready !== 1'b1 && lowcnt < 20) begin
            lowcnt++;
            @(negedge clk_2);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; clr = 1'b0; res_valid = 1'b1; res_in = 3'sd3;
        repeat (2) @(negedge clk_2);
        checks++; if (acc !== 4'sd0) begin errors++; $display("FAIL reset_acc: got %0d required 0", acc); end
        checks++; if (ovf !== 1'b0 || unf !== 1'b0) begin errors++; $display("FAIL reset_flags: got ovf=%b unf=%b required 0 0", ovf, unf); end
        checks++; if (SEG !== 8'b00111111) begin errors++; $display("FAIL reset_seg: got %b required 00111111", SEG); end
        checks++; if (res_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_ctrl: got ready=%b busy=%b required 1 0", res_ready, busy); end
        res_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk_2);
    endtask

    task automatic test_accumulate();
        int lc;
        push(3'sd3, lc);
        checks++; if (acc !== 4'sd3) begin errors++; $display("FAIL acc_first: got %0d required 3", acc); end
        checks++; if (SEG !== 8'b01001111) begin errors++; $display("FAIL seg_first: got %b required 01001111", SEG); end
        checks++; if (lc !== 3) begin errors++; $display("FAIL ready_low_first: got %0d cycles required 3", lc); end
        push(3'sd3, lc);
        checks++; if (acc !== 4'sd6) begin errors++; $display("FAIL acc_second: got %0d required 6", acc); end
        checks++; if (SEG !== 8'b01111101) begin errors++; $display("FAIL seg_second: got %b required 01111101", SEG); end
        checks++; if (ovf !== 1'b0 || unf !== 1'b0) begin errors++; $display("FAIL flags_second: got ovf=%b unf=%b required 0 0", ovf, unf); end
        checks++; if (lc !== 3) begin errors++; $display("FAIL ready_low_second: got %0d cycles required 3", lc); end
    endtask

    task automatic test_overflow_clr();
        int lc;
        push(3'sd3, lc);
        checks++; if (acc !== 4'sd7 || ovf !== 1'b1) begin errors++; $display("FAIL ovf_sat: got acc=%0d ovf=%b required 7 1", acc, ovf); end
        checks++; if (SEG !== 8'b10111111) begin errors++; $display("FAIL ovf_seg: got %b required 10111111", SEG); end
        push(-3'sd4, lc);
        checks++; if (acc !== 4'sd3 || ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got acc=%0d ovf=%b required 3 1", acc, ovf); end
        checks++; if (SEG !== 8'b10111111) begin errors++; $display("FAIL ovf_sticky_seg: got %b required 10111111", SEG); end
        clr = 1'b1;
        @(negedge clk_2);
        clr = 1'b0;
        checks++; if (acc !== 4'sd0 || ovf !== 1'b0) begin errors++; $display("FAIL clr_state: got acc=%0d ovf=%b required 0 0", acc, ovf); end
        checks++; if (SEG !== 8'b00111111) begin errors++; $display("FAIL clr_seg: got %b required 00111111", SEG); end
    endtask

    task automatic test_underflow();
        int lc;
        apply_reset();
        push(-3'sd4, lc);
        checks++; if (acc !== -4'sd4 || SEG !== 8'b11100110) begin errors++; $display("FAIL neg4: got acc=%0d seg=%b required -4 11100110", acc, SEG); end
        push(-3'sd4, lc);
        checks++; if (acc !== -4'sd8 || SEG !== 8'b11111111 || unf !== 1'b0) begin errors++; $display("FAIL neg8: got acc=%0d seg=%b unf=%b required -8 11111111 0", acc, SEG, unf); end
        push(-3'sd1, lc);
`ifdef ALU_ACC_WRAP_EN
        checks++; if (acc !== 4'sd7) begin errors++; $display("FAIL unf_acc: got %0d required 7", acc); end
`else
        checks++; if (acc !== -4'sd8) begin errors++; $display("FAIL unf_acc: got %0d required -8", acc); end
`endif
        checks++; if (unf !== 1'b1 || ovf !== 1'b0) begin errors++; $display("FAIL unf_flags: got unf=%b ovf=%b required 1 0", unf, ovf); end
        checks++; if (SEG !== 8'b10111110) begin errors++; $display("FAIL unf_seg: got %b required 10111110", SEG); end
    endtask

    task automatic test_back_to_back();
        int n;
        int t[3];
        apply_reset();
        n = 0;
        res_in = 3'sd1; res_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (res_ready === 1'b1) begin
                if (n < 3) t[n] = i;
                n++;
            end
            @(negedge clk_2);
        end
        res_valid = 1'b0;
        repeat (4) @(negedge clk_2);
        checks++; if (n !== 3) begin errors++; $display("FAIL b2b_count: got %0d transfers required 3", n); end
        if (n >= 3) begin
            checks++; if (t[1] - t[0] !== 4 || t[2] - t[1] !== 4) begin errors++; $display("FAIL b2b_spacing: got %0d,%0d required 4,4", t[1] - t[0], t[2] - t[1]); end
        end
        checks++; if (acc !== 4'sd3) begin errors++; $display("FAIL b2b_acc: got %0d required 3", acc); end
    endtask

    task automatic test_reset_in_exec();
        apply_reset();
        res_in = 3'sd2; res_valid = 1'b1;
        @(negedge clk_2);
        res_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL exec_entered: got busy=%b required 1", busy); end
        reset = 1'b0;
        @(negedge clk_2);
        reset = 1'b1;
        checks++; if (acc !== 4'sd0 || SEG !== 8'b00111111) begin errors++; $display("FAIL exec_reset: got acc=%0d seg=%b required 0 00111111", acc, SEG); end
        checks++; if (res_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL exec_reset_ctrl: got ready=%b busy=%b required 1 0", res_ready, busy); end
        repeat (3) @(negedge clk_2);
        checks++; if (acc !== 4'sd0) begin errors++; $display("FAIL exec_reset_late: got acc=%0d required 0", acc); end
    endtask

    task automatic test_clr_handshake();
        int lc;
        apply_reset();
        push(3'sd1, lc);
        checks++; if (acc !== 4'sd1) begin errors++; $display("FAIL clr_pre: got acc=%0d required 1", acc); end
        res_in = 3'sd3; res_valid = 1'b1; clr = 1'b1;
        @(negedge clk_2);
        res_valid = 1'b0; clr = 1'b0;
        checks++; if (acc !== 4'sd0 || busy !== 1'b0 || res_ready !== 1'b1) begin errors++; $display("FAIL clr_drop: got acc=%0d busy=%b ready=%b required 0 0 1", acc, busy, res_ready); end
        repeat (4) @(negedge clk_2);
        checks++; if (acc !== 4'sd0 || SEG !== 8'b00111111) begin errors++; $display("FAIL clr_drop_late: got acc=%0d seg=%b required 0 00111111", acc, SEG); end
    endtask

    initial begin
        reset = 1'b0; clr = 1'b0; res_valid = 1'b0; res_in = '0;
        @(negedge clk_2);
        test_reset();
        test_accumulate();
        test_overflow_clr();
        test_underflow();
        test_back_to_back();
        test_reset_in_exec();
        test_clr_handshake();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
